// File: rtl/rgb2gray_stream.sv
// Streaming RGB to greyscale converter: 3-stage valid/ready pipeline with selectable weights.
// Define RGB2GRAY_STREAM_ROUND_EN to round half up instead of truncating the weighted sum.
module rgb2gray_stream #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] red_i,
  input  logic [PIX_W-1:0] green_i,
  input  logic [PIX_W-1:0] blue_i,
  input  logic [1:0]       mode_i,
  input  logic             sof_i,
  input  logic             eol_i,
  input  logic             done_i,
  output logic             ready_o,
  output logic [PIX_W-1:0] grayscale_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic [CNT_W-1:0] pix_cnt_o,
  output logic             done_o,
  input  logic             ready_i
);

  localparam int unsigned ProdW = PIX_W + 9;
  localparam int unsigned SumW  = PIX_W + 10;

  logic en;

  // Stage 1: weighted products
  logic [8:0]       coef_r, coef_g, coef_b;
  logic [ProdW-1:0] prod_r_d, prod_g_d, prod_b_d;
  logic [ProdW-1:0] prod_r_q, prod_g_q, prod_b_q;
  logic             v1_q, sof1_q, eol1_q;

  // Stage 2: sum
  logic [SumW-1:0]  sum_d, sum_q;
  logic             v2_q, sof2_q, eol2_q;

  // Stage 3: output
  logic [SumW-1:0]  rnd_sum;
  logic [PIX_W-1:0] gray_d, gray_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             sof3_q, eol3_q, v3_q;
  logic             unused_rnd_bits;

  assign en      = ready_i | ~v3_q;
  assign ready_o = en;

  always_comb begin
    coef_r = 9'd77;
    coef_g = 9'd150;
    coef_b = 9'd29;
    unique case (mode_i)
      2'd0: begin coef_r = 9'd77; coef_g = 9'd150; coef_b = 9'd29; end
      2'd1: begin coef_r = 9'd54; coef_g = 9'd183; coef_b = 9'd19; end
      2'd2: begin coef_r = 9'd85; coef_g = 9'd86;  coef_b = 9'd85; end
      2'd3: begin coef_r = 9'd0;  coef_g = 9'd256; coef_b = 9'd0;  end
      default: ;
    endcase
  end

  // Mode is applied here, so the pixel carries its weights through the remaining stages.
  always_comb begin
    prod_r_d = ProdW'(red_i)   * ProdW'(coef_r);
    prod_g_d = ProdW'(green_i) * ProdW'(coef_g);
    prod_b_d = ProdW'(blue_i)  * ProdW'(coef_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      sof1_q   <= 1'b0;
      eol1_q   <= 1'b0;
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
    end else if (en) begin
      v1_q <= done_i;
      if (done_i) begin
        sof1_q   <= sof_i;
        eol1_q   <= eol_i;
        prod_r_q <= prod_r_d;
        prod_g_q <= prod_g_d;
        prod_b_q <= prod_b_d;
      end
    end
  end

  always_comb begin
    sum_d = SumW'(prod_r_q) + SumW'(prod_g_q) + SumW'(prod_b_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q   <= 1'b0;
      sof2_q <= 1'b0;
      eol2_q <= 1'b0;
      sum_q  <= '0;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sof2_q <= sof1_q;
        eol2_q <= eol1_q;
        sum_q  <= sum_d;
      end
    end
  end

  always_comb begin
`ifdef RGB2GRAY_STREAM_ROUND_EN
    rnd_sum = sum_q + SumW'(128);
`else
    rnd_sum = sum_q;
`endif
    // Weights sum to 256, so the selected field cannot exceed full scale.
    gray_d          = rnd_sum[PIX_W+7:8];
    unused_rnd_bits = ^{rnd_sum[SumW-1:PIX_W+8], rnd_sum[7:0]};
    cnt_d           = sof2_q ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q   <= 1'b0;
      sof3_q <= 1'b0;
      eol3_q <= 1'b0;
      gray_q <= '0;
      cnt_q  <= '0;
    end else if (en) begin
      v3_q <= v2_q;
      if (v2_q) begin
        sof3_q <= sof2_q;
        eol3_q <= eol2_q;
        gray_q <= gray_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign grayscale_o = gray_q;
  assign sof_o       = sof3_q;
  assign eol_o       = eol3_q;
  assign pix_cnt_o   = cnt_q;
  assign done_o      = v3_q;

endmodule

// File: doc/rgb2gray_stream.md
RGB2GRAY_STREAM -- requirements
Module: rgb2gray_stream

Interface
REQ-001 The block SHALL have these parameters:
- PIX_W, default 8, bits per colour channel and per grey output.
- CNT_W, default 16, width of the per-frame pixel index counter.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- red_i  in  PIX_W  red sample.
- green_i  in  PIX_W  green sample.
- blue_i  in  PIX_W  blue sample.
- mode_i  in  2  weight set: 0 BT.601, 1 BT.709, 2 average, 3 green-only.
- sof_i  in  1  start-of-frame marker for this pixel.
- eol_i  in  1  end-of-line marker for this pixel.
- done_i  in  1  input pixel valid.
- ready_o  out  1  block can accept an input pixel.
- grayscale_o  out  PIX_W  grey result.
- sof_o  out  1  delayed sof_i.
- eol_o  out  1  delayed eol_i.
- pix_cnt_o  out  CNT_W  index of the output pixel within its frame.
- done_o  out  1  output pixel valid.
- ready_i  in  1  downstream can accept an output pixel.

Function
REQ-003 The block SHALL define the pipeline advance condition as en = ready_i OR NOT done_o, and SHALL drive ready_o = en combinationally.
- Input transfer: done_i AND ready_o in the same cycle.
- Output transfer: done_o AND ready_i in the same cycle.

REQ-004 The block SHALL be a 3-stage pipeline with a latency of 3 cycles from input transfer to done_o when en stays 1.
- S1 registers the three products.
- S2 registers the sum.
- S3 registers the grey value, sof_o, eol_o, pix_cnt_o and done_o.

REQ-005 When en=0, every stage SHALL hold its contents, and grayscale_o, sof_o, eol_o and pix_cnt_o SHALL stay stable while done_o=1.

REQ-006 Coefficients SHALL be 8-bit fractions (/256) per mode, each set summing to 256:
- mode 0: 77/150/29.
- mode 1: 54/183/19.
- mode 2: 85/86/85.
- mode 3: 0/256/0.

REQ-007 mode_i SHALL be sampled at input transfer and carried with the pixel, so a mode change affects only pixels accepted afterwards.

REQ-008 Products SHALL be PIX_W+9 bits and the sum SHALL be PIX_W+10 bits unsigned, so no overflow occurs.

REQ-009 grayscale_o SHALL be bits [PIX_W+7:8] of the final sum.
- The result never exceeds 2^PIX_W-1, so no clamp is required.

REQ-010 Per-stage valid bits SHALL propagate done_i, and bubbles (done_i=0) SHALL advance through the pipeline like data when en=1.

REQ-011 On each S3 load of a valid pixel, pix_cnt_o SHALL be set as follows:
- 0 if that pixel's sof is 1.
- Otherwise the previous value +1, wrapping from 2^CNT_W-1 to 0.

REQ-012 pix_cnt_o SHALL be unchanged by bubbles and stalls.

REQ-013 done_i with ready_o=0 SHALL NOT be captured; the upstream must hold the pixel until ready_o=1.

REQ-014 When an input transfer and an output transfer occur in the same cycle, both SHALL complete with no loss, giving a sustained throughput of 1 pixel/cycle.

Reset
REQ-015 Asserting rst SHALL immediately and asynchronously clear:
- all stage valid bits, done_o, sof_o, eol_o, grayscale_o (0) and pix_cnt_o (0);
- all data registers (0).

REQ-016 Pixels in flight when rst asserts mid-operation SHALL be discarded and SHALL NOT appear after reset.

REQ-017 While rst=1, ready_o SHALL be 1 (because done_o=0), but no input SHALL be captured.

REQ-018 After rst deasserts, the first input transfer SHALL occur at the first rising edge at which done_i=1.

Configuration
REQ-019 The macro RGB2GRAY_STREAM_ROUND_EN SHALL select rounding:
- Defined: S3 adds 128 to the sum before the bit select (round half up).
- Undefined: S3 truncates.
- Latency and the interface SHALL be identical in both builds.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Mode 0, PIX_W=8, r=36 g=106 b=144, ready_i=1 -> grayscale_o=89, done_o high exactly 3 cycles after the transfer.
- Mode 0, r=2 g=0 b=0 -> 1 with RGB2GRAY_STREAM_ROUND_EN defined, 0 without; mode 2, r=36 g=106 b=144 -> 95; any mode, 255/255/255 -> 255.
- Back-to-back 5 pixels, ready_i=0 for cycles 4-6 -> ready_o=0 in those cycles, outputs stable, all 5 results in order with no loss or duplication.
- Mode 1 pixel followed by a mode 3 pixel with r=200 g=10 b=50 -> the first result uses BT.709 weights, the second result is 10.
- sof_i on pixel 0 of a 4-pixel burst, then sof_i again -> pix_cnt_o 0,1,2,3,0; eol_o aligned with its pixel; CNT_W=2 wraps 3->0 without sof.
- rst pulsed mid-burst with 2 pixels in flight -> done_o=0 immediately, pix_cnt_o=0, no stale pixel after release.
